// File: rtl/bird_ctrl_pkg.sv
// Shared types and video-slot address map for the bird sprite sequencer.
package bird_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_WR_X,
    S_WR_Y,
    S_WR_CTRL
  } state_e;

  localparam logic [13:0] ADDR_BYPASS = 14'h2000;
  localparam logic [13:0] ADDR_X0     = 14'h2001;
  localparam logic [13:0] ADDR_Y0     = 14'h2002;
  localparam logic [13:0] ADDR_CTRL   = 14'h2003;

endpackage

// File: rtl/bird_motion_ctrl.sv
// Per-frame bird physics/animation update followed by three register writes
// (x0, y0, ctrl) on the sprite core's video-slot bus.
module bird_motion_ctrl
  import bird_ctrl_pkg::*;
#(
  parameter int unsigned X_POS     = 160,
  parameter int unsigned Y_START   = 200,
  parameter int unsigned Y_MAX     = 448,
  parameter int unsigned GRAVITY   = 1,
  parameter int unsigned FLAP_V    = 8,
  parameter int unsigned TERM_V    = 10,
  parameter int unsigned ANIM_DIV  = 6,
  parameter logic [2:0]  CTRL_BASE = 3'b001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_start,
  input  logic        enable,
  input  logic        flap,
  output logic        cs,
  output logic        write,
  output logic [13:0] addr,
  output logic [31:0] wr_data,
  output logic        busy,
  output logic        on_floor,
  output logic [10:0] y_pos
);

  localparam logic [10:0]        Y_START_L = 11'(Y_START);
  localparam logic [10:0]        Y_MAX_L   = 11'(Y_MAX);
  localparam logic signed [11:0] Y_MAX_S   = 12'(Y_MAX);
  localparam logic signed [8:0]  GRAV_S    = 9'(GRAVITY);
  localparam logic signed [8:0]  TERM_S    = 9'(TERM_V);
  localparam logic signed [7:0]  FLAP_NEG  = -8'(FLAP_V);
  localparam logic [7:0]         DIV_LAST  = 8'(ANIM_DIV - 1);

  state_e             state_q, state_d;
  logic [10:0]        y_q, y_d;
  logic signed [7:0]  v_q, v_d;
  logic               flap_q, flap_d;
  logic [7:0]         div_q, div_d;
  logic [1:0]         frame_q, frame_d;
  logic [1:0]         wr_idx_q, wr_idx_d;

  logic signed [8:0]  v_inc;
  logic signed [7:0]  v_new;
  logic signed [11:0] y_sum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      y_q      <= Y_START_L;
      v_q      <= '0;
      flap_q   <= 1'b0;
      div_q    <= '0;
      frame_q  <= '0;
      wr_idx_q <= '0;
    end else begin
      state_q  <= state_d;
      y_q      <= y_d;
      v_q      <= v_d;
      flap_q   <= flap_d;
      div_q    <= div_d;
      frame_q  <= frame_d;
      wr_idx_q <= wr_idx_d;
    end
  end

  always_comb begin
    v_inc = {v_q[7], v_q} + GRAV_S;
    if (flap_q || flap)
      v_new = FLAP_NEG;
    else if (v_inc > TERM_S)
      v_new = TERM_S[7:0];
    else
      v_new = v_inc[7:0];
    y_sum = $signed({1'b0, y_q}) + $signed({{4{v_new[7]}}, v_new});
  end

  always_comb begin
    state_d  = state_q;
    y_d      = y_q;
    v_d      = v_q;
    flap_d   = flap_q | flap;
    div_d    = div_q;
    frame_d  = frame_q;
    wr_idx_d = wr_idx_q;
    unique case (state_q)
      S_IDLE: if (frame_start && enable) state_d = S_CALC;
      S_CALC: begin
        state_d = S_WR_X;
        flap_d  = 1'b0;
        if (y_sum < 0) begin
          y_d = '0;
          v_d = '0;
        end else if (y_sum > Y_MAX_S) begin
          y_d = Y_MAX_L;
          v_d = '0;
        end else begin
          y_d = y_sum[10:0];
          v_d = v_new;
        end
        // The ctrl write carries the index in effect before this frame's
        // advance, so each index value is shown for a full ANIM_DIV frames.
        wr_idx_d = frame_q;
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          frame_d = frame_q + 2'd1;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      S_WR_X:    state_d = S_WR_Y;
      S_WR_Y:    state_d = S_WR_CTRL;
      S_WR_CTRL: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cs      = 1'b0;
    write   = 1'b0;
    addr    = '0;
    wr_data = '0;
    unique case (state_q)
      S_WR_X: begin
        cs      = 1'b1;
        write   = 1'b1;
        addr    = ADDR_X0;
        wr_data = 32'(X_POS);
      end
      S_WR_Y: begin
        cs      = 1'b1;
        write   = 1'b1;
        addr    = ADDR_Y0;
        wr_data = {21'd0, y_q};
      end
      S_WR_CTRL: begin
        cs      = 1'b1;
        write   = 1'b1;
        addr    = ADDR_CTRL;
        wr_data = {27'd0, CTRL_BASE, wr_idx_q};
      end
      default: ;
    endcase
  end

  assign busy     = (state_q != S_IDLE);
  assign on_floor = (y_q == Y_MAX_L);
  assign y_pos    = y_q;

endmodule

// File: tb/tb_bird_motion_ctrl.sv
// Directed, table-driven bench for bird_motion_ctrl with default parameters.
module tb_bird_motion_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_start;
  logic        enable;
  logic        flap;
  logic        cs;
  logic        write;
  logic [13:0] addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        on_floor;
  logic [10:0] y_pos;

  int errors = 0;
  int checks = 0;
  int nfr    = 0;

  bird_motion_ctrl #(
    .X_POS(160), .Y_START(200), .Y_MAX(448), .GRAVITY(1),
    .FLAP_V(8), .TERM_V(10), .ANIM_DIV(6), .CTRL_BASE(3'b001)
  ) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .enable(enable),
    .flap(flap), .cs(cs), .write(write), .addr(addr), .wr_data(wr_data),
    .busy(busy), .on_floor(on_floor), .y_pos(y_pos)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          fs_busy;
    logic [10:0] y;
    logic [4:0]  ctrl;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Written animation index: one step every 6 frames counted from reset.
  function automatic logic [4:0] ctrl_of(input int n);
    logic [1:0] idx;
    idx = 2'((n / 6) % 4);
    return {3'b001, idx};
  endfunction

  task automatic idle_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_cs"}, 32'(cs), 0);
    chk({tag, "_write"}, 32'(write), 0);
    chk({tag, "_addr"}, 32'(addr), 0);
    chk({tag, "_data"}, wr_data, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; frame_start = 1'b0; flap = 1'b0; enable = 1'b1;
    @(negedge clk);
    idle_outputs("rst");
    chk("rst_y", 32'(y_pos), 200);
    chk("rst_floor", 32'(on_floor), 0);
    reset = 1'b0;
    nfr = 0;
  endtask

  task automatic pulse_flap();
    @(negedge clk); flap = 1'b1;
    @(negedge clk); flap = 1'b0;
  endtask

  // flap_at: cycle offset of a flap pulse (0 = frame_start cycle, 1 = CALC,
  // 2 = WR_X, 3 = WR_Y, 4 = WR_CTRL), -1 for none.
  task automatic run_frame(input bit fs_busy, input int flap_at, input bit drop_en,
                           input logic [10:0] exp_y, input logic [4:0] exp_ctrl);
    @(negedge clk);
    frame_start = 1'b1; flap = (flap_at == 0);
    @(negedge clk);
    frame_start = fs_busy; flap = (flap_at == 1);
    if (drop_en) enable = 1'b0;
    chk("calc_busy", 32'(busy), 1);
    chk("calc_cs", 32'(cs), 0);
    chk("calc_addr", 32'(addr), 0);
    chk("calc_data", wr_data, 0);
    @(negedge clk);
    flap = (flap_at == 2);
    chk("wx_cs", 32'({cs, write, busy}), 3'b111);
    chk("wx_addr", 32'(addr), 32'h2001);
    chk("wx_data", wr_data, 160);
    chk("y_pos", 32'(y_pos), 32'(exp_y));
    @(negedge clk);
    flap = (flap_at == 3);
    chk("wy_cs", 32'({cs, write, busy}), 3'b111);
    chk("wy_addr", 32'(addr), 32'h2002);
    chk("wy_data", wr_data, 32'(exp_y));
    @(negedge clk);
    flap = (flap_at == 4);
    chk("wc_cs", 32'({cs, write, busy}), 3'b111);
    chk("wc_addr", 32'(addr), 32'h2003);
    chk("wc_data", wr_data, 32'(exp_ctrl));
    @(negedge clk);
    flap = 1'b0; frame_start = 1'b0;
    idle_outputs("post");
    nfr++;
  endtask

  initial begin
    logic [10:0] y;
    reset = 1'b1; frame_start = 1'b0; enable = 1'b0; flap = 1'b0;

    tbl[0]  = '{0, 11'd201, 5'h04};
    tbl[1]  = '{0, 11'd203, 5'h04};
    tbl[2]  = '{1, 11'd206, 5'h04};
    tbl[3]  = '{0, 11'd210, 5'h04};
    tbl[4]  = '{0, 11'd215, 5'h04};
    tbl[5]  = '{0, 11'd221, 5'h04};
    tbl[6]  = '{0, 11'd228, 5'h05};
    tbl[7]  = '{0, 11'd236, 5'h05};
    tbl[8]  = '{1, 11'd245, 5'h05};
    tbl[9]  = '{0, 11'd255, 5'h05};
    tbl[10] = '{0, 11'd265, 5'h05};
    tbl[11] = '{0, 11'd275, 5'h05};
    tbl[12] = '{0, 11'd285, 5'h06};

    do_reset();

    // Gravity ramp to terminal velocity and animation stepping
    for (int i = 0; i < 13; i++)
      run_frame(tbl[i].fs_busy, -1, 1'b0, tbl[i].y, tbl[i].ctrl);

    // Terminal velocity descent down to the floor clamp
    y = 11'd285;
    for (int k = 0; k < 16; k++) begin
      y = y + 11'd10;
      run_frame(1'b0, -1, 1'b0, y, ctrl_of(nfr));
    end
    chk("above_floor", 32'(on_floor), 0);
    run_frame(1'b0, -1, 1'b0, 11'd448, ctrl_of(nfr));
    chk("on_floor", 32'(on_floor), 1);
    // v was zeroed by the clamp: 448 + 1 clamps again
    run_frame(1'b0, -1, 1'b0, 11'd448, ctrl_of(nfr));
    chk("still_floor", 32'(on_floor), 1);

    // Single flap between frames
    do_reset();
    pulse_flap();
    run_frame(1'b0, -1, 1'b0, 11'd192, ctrl_of(nfr));

    // Two flaps collapse into one; following frame v = -7
    do_reset();
    pulse_flap();
    pulse_flap();
    run_frame(1'b0, -1, 1'b0, 11'd192, ctrl_of(nfr));
    run_frame(1'b0, -1, 1'b0, 11'd185, ctrl_of(nfr));

    // Climb to the ceiling with flaps in the frame_start and CALC cycles
    do_reset();
    y = 11'd200;
    for (int k = 0; k < 24; k++) begin
      y = y - 11'd8;
      run_frame(1'b0, (k % 2 == 0) ? 0 : 1, 1'b0, y, ctrl_of(nfr));
    end
    // Flap during WR_Y is latched for the next frame only
    run_frame(1'b0, 3, 1'b0, 11'd1, ctrl_of(nfr));
    run_frame(1'b0, -1, 1'b0, 11'd0, ctrl_of(nfr));
    chk("top_floor", 32'(on_floor), 0);
    run_frame(1'b0, -1, 1'b0, 11'd1, ctrl_of(nfr));

    // Reset during WR_Y aborts the sequence
    do_reset();
    @(negedge clk); frame_start = 1'b1;
    @(negedge clk); frame_start = 1'b0;
    @(negedge clk);
    chk("pre_abort_addr", 32'(addr), 32'h2001);
    @(negedge clk);
    chk("wy_before_abort", 32'(addr), 32'h2002);
    reset = 1'b1;
    #1;
    idle_outputs("abort");
    chk("abort_y", 32'(y_pos), 200);
    @(negedge clk);
    reset = 1'b0;
    idle_outputs("abort_n1");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("abort_quiet", 32'({busy, cs, write}), 0);
    end
    chk("abort_y2", 32'(y_pos), 200);

    // Enable dropped during CALC: sequence completes, none follows
    nfr = 0;
    run_frame(1'b0, -1, 1'b1, 11'd201, ctrl_of(nfr));
    @(negedge clk); frame_start = 1'b1;
    @(negedge clk); frame_start = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk("dis_quiet", 32'({busy, cs, write}), 0);
      @(negedge clk);
    end
    chk("dis_y_held", 32'(y_pos), 201);
    enable = 1'b1;
    run_frame(1'b0, -1, 1'b0, 11'd203, ctrl_of(nfr));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bird_motion_ctrl.md
# bird_motion_ctrl

Per-frame sequencer for the bird sprite register slot. On each frame-start pulse it advances the bird's vertical physics (gravity, flap, clamping) and its wing-animation counter, then issues three single-cycle writes (x0, y0, ctrl) on the video-slot bus of the bird sprite core. It sits between the game-logic inputs (flap button, enable) and the sprite core's `cs/write/addr/wr_data` slot, replacing software register writes.

## Interface
- `X_POS`, default 160: fixed horizontal sprite position written to x0.
- `Y_START`, default 200: y position after reset.
- `Y_MAX`, default 448: lowest legal y (floor); top limit is 0.
- `GRAVITY`, default 1: velocity increment per frame.
- `FLAP_V`, default 8: on flap, velocity is set to −FLAP_V.
- `TERM_V`, default 10: maximum downward velocity.
- `ANIM_DIV`, default 6: frames per animation step.
- `CTRL_BASE`, default 3'b001: ctrl[4:2] value written each frame.
- `clk` in 1: system clock. One clock domain.
- `reset` in 1: asynchronous, active-high.
- `frame_start` in 1: one-cycle pulse at start of vertical blank.
- `enable` in 1: level; physics and writes run only when high.
- `flap` in 1: one-cycle pulse; latched until consumed.
- `cs` out 1: slot select, asserted with `write`.
- `write` out 1: write strobe.
- `addr` out 14: slot address.
- `wr_data` out 32: write data, zero-extended.
- `busy` out 1: high while a sequence is in progress.
- `on_floor` out 1: high while y == Y_MAX.
- `y_pos` out 11: current y, for collision logic.

## Operation
- States: IDLE, CALC, WR_X, WR_Y, WR_CTRL; each state other than IDLE lasts one cycle.
- IDLE → CALC when `frame_start & enable`. `frame_start` is ignored in any other state or when `enable` is low.
- CALC:
  - If the flap latch is set (or `flap` is high in this same cycle), v = −FLAP_V. Otherwise v = min(v + GRAVITY, TERM_V).
  - y_next = y + v, computed in 12-bit signed arithmetic.
  - If y_next < 0: y = 0 and v = 0.
  - If y_next > Y_MAX: y = Y_MAX and v = 0.
  - Clear the flap latch.
  - Advance the animation divider. When it reaches ANIM_DIV−1, it returns to 0 and frame_idx increments modulo 4 (3 → 0).
- WR_X: addr = 14'h2001, wr_data = X_POS.
- WR_Y: addr = 14'h2002, wr_data = updated y.
- WR_CTRL: addr = 14'h2003, wr_data = {CTRL_BASE, frame_idx}. Then return to IDLE.
- The block never writes sprite RAM (addr[13] = 0) or bypass (14'h2000).
- Velocity register: signed 8-bit.
- The flap latch is set by `flap` in any state, including while `busy`. Multiple flaps before CALC collapse into one.
- `enable` falling mid-sequence: the sequence completes; no further sequences start. Physics state is held.

## Timing
- `frame_start` sampled at edge T: CALC occupies cycle T+1, writes at T+2, T+3, T+4, and back in IDLE at T+5.
- `cs` = `write` = 1 exactly in WR_X, WR_Y and WR_CTRL; 0 otherwise.
- `addr` and `wr_data` are 0 when not writing.
- `busy` is high from T+1 through T+4.
- `y_pos` and `on_floor` update at the end of CALC.
- Reset values:
  - Outputs: cs = write = busy = 0, addr = 0, wr_data = 0, y_pos = Y_START, on_floor = 0.
  - Internal: v = 0, flap latch = 0, frame_idx = 0, divider = 0, state IDLE.
- Reset asserted mid-sequence aborts immediately to reset values; the remaining writes are not issued.

## Structure
- Package `bird_ctrl_pkg` holds:
  - the state enum type;
  - slot address constants: ADDR_BYPASS = 14'h2000, ADDR_X0 = 14'h2001, ADDR_Y0 = 14'h2002, ADDR_CTRL = 14'h2003.
- Single module; no sub-module is warranted. Physics is one combinational block feeding registers.

## Test plan
- Reset, then `enable` = 1 and one `frame_start` → writes 14'h2001/160, 14'h2002/201, 14'h2003/0x04 on consecutive cycles; v = 1; `busy` high for 4 cycles.
- Twenty frames with no flap → v saturates at 10. y sequence starts 201, 203, 206 and rises until clamped at 448; `on_floor` = 1 and v = 0.
- `flap` pulse between frames with y = 200 → next frame writes y = 192, v = −8. Two flaps before one frame give the same result.
- Flap near the top with y = 5 → y clamps to 0 and v = 0. The following frame writes y = 1.
- Drive `frame_start` on 13 consecutive frames → ctrl[1:0] goes 0 for 6 frames, 1 for 6 frames, then 2. `frame_start` asserted while `busy` produces no extra writes.
- Assert `reset` in the cycle of WR_Y → no WR_CTRL write, all outputs at reset values the next cycle. Separately, drop `enable` during CALC → all three writes still occur; no sequence follows.
